// File: rtl/flow_ctrl_tx_pause_if.sv
// Purpose: bundle of signals between the RX pause decoder, the TX frame engine and the pause responder.
// Latency: none, wires only.
// Backpressure: the engine holds its requests until granted; grants are one-cycle pulses.
//
// Signals:
//   pause_respect_en   honour received PAUSE frames
//   pause_rcvd         one-cycle strobe, valid PAUSE frame decoded
//   pause_quanta_rcvd  quanta carried by that frame (qualified by pause_rcvd)
//   tx_frame_req       engine wants to start a data frame (held until granted)
//   ctrl_frame_req     engine wants to start a MAC control frame (held until granted)
//   tx_frame_busy      engine is transmitting the granted frame
//   tx_frame_go        one-cycle data frame grant
//   ctrl_frame_go      one-cycle control frame grant
//   pause_apply        pause timer non-zero
//   pause_frames_cnt   saturating count of honoured non-zero PAUSE frames
//   paused_cycles      wrapping count of cycles a data request was held off by pause
interface flow_ctrl_tx_pause_if;
    logic        pause_respect_en;
    logic        pause_rcvd;
    logic [15:0] pause_quanta_rcvd;
    logic        tx_frame_req;
    logic        ctrl_frame_req;
    logic        tx_frame_busy;
    logic        tx_frame_go;
    logic        ctrl_frame_go;
    logic        pause_apply;
    logic [15:0] pause_frames_cnt;
    logic [31:0] paused_cycles;

    // Driving side: RX decoder plus TX frame engine.
    modport master (
        output pause_respect_en, pause_rcvd, pause_quanta_rcvd,
               tx_frame_req, ctrl_frame_req, tx_frame_busy,
        input  tx_frame_go, ctrl_frame_go, pause_apply,
               pause_frames_cnt, paused_cycles
    );

    // Responder side.
    modport slave (
        input  pause_respect_en, pause_rcvd, pause_quanta_rcvd,
               tx_frame_req, ctrl_frame_req, tx_frame_busy,
        output tx_frame_go, ctrl_frame_go, pause_apply,
               pause_frames_cnt, paused_cycles
    );
endinterface

// File: rtl/flow_ctrl_tx_pause.sv
// Purpose: 802.3x TX pause responder; turns decoded PAUSE quanta into a byte-clock hold-off on data frame starts.
// Latency: PAUSE strobe -> pause_apply next cycle; request -> grant one cycle after it is seen unblocked in IDLE.
// Backpressure: data starts are withheld while paused; control frames and in-flight frames are never held.
//
// Ports:
//   tx_clk    TX byte clock (only clock)
//   tx_reset  asynchronous active-high reset
//   fc        flow_ctrl_tx_pause_if.slave (pause input, engine handshake, status/statistics)
// CNT_W must be at least 16+QUANTA_SHIFT so the largest quanta value fits the timer.
module flow_ctrl_tx_pause #(
    parameter int QUANTA_SHIFT = 6,
    parameter int CNT_W        = 22
) (
    input  logic                   tx_clk,
    input  logic                   tx_reset,
    flow_ctrl_tx_pause_if.slave    fc
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GO_DATA    = 3'd1,
        GO_CTRL    = 3'd2,
        WAIT_START = 3'd3,
        WAIT_END   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             pause_apply_q;
    logic [15:0]      pause_frames_q;
    logic [31:0]      paused_cycles_q;

    logic             xoff_now;
    logic             block;

    // A non-zero PAUSE arriving this very cycle must already block a grant,
    // otherwise a data frame could slip out one cycle after the PAUSE.
    assign xoff_now = fc.pause_rcvd & fc.pause_respect_en & (fc.pause_quanta_rcvd != 16'd0);
    assign block    = pause_apply_q | xoff_now;

    // ---------------- pause timer ----------------
    // A new frame replaces the remaining time (quanta 0 = XON clears it).
    always_comb begin
        timer_nxt = timer;
        if (!fc.pause_respect_en) begin
            timer_nxt = '0;
        end else if (fc.pause_rcvd) begin
            timer_nxt = CNT_W'(fc.pause_quanta_rcvd) << QUANTA_SHIFT;
        end else if (timer != '0) begin
            timer_nxt = timer - CNT_W'(1);
        end
    end

    // pause_apply is registered from timer_nxt so it always equals (timer != 0).
    always_ff @(posedge tx_clk or posedge tx_reset) begin
        if (tx_reset) begin
            timer         <= '0;
            pause_apply_q <= 1'b0;
        end else begin
            timer         <= timer_nxt;
            pause_apply_q <= (timer_nxt != '0);
        end
    end

    // ---------------- grant FSM: state register ----------------
    always_ff @(posedge tx_clk or posedge tx_reset) begin
        if (tx_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- grant FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fc.ctrl_frame_req) begin
                    state_nxt = GO_CTRL;
                end else if (fc.tx_frame_req && !block) begin
                    state_nxt = GO_DATA;
                end
            end
            // Busy may already be up in the grant cycle; skip the start wait then.
            GO_DATA, GO_CTRL: begin
                state_nxt = fc.tx_frame_busy ? WAIT_END : WAIT_START;
            end
            WAIT_START: begin
                if (fc.tx_frame_busy) begin
                    state_nxt = WAIT_END;
                end
            end
            WAIT_END: begin
                if (!fc.tx_frame_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- grant FSM: outputs ----------------
    // Decoded from the state register alone, so each grant is a clean single-cycle pulse.
    always_comb begin
        fc.tx_frame_go   = 1'b0;
        fc.ctrl_frame_go = 1'b0;
        case (state)
            GO_DATA: fc.tx_frame_go   = 1'b1;
            GO_CTRL: fc.ctrl_frame_go = 1'b1;
            default: ;
        endcase
    end

    // ---------------- statistics ----------------
    always_ff @(posedge tx_clk or posedge tx_reset) begin
        if (tx_reset) begin
            pause_frames_q  <= '0;
            paused_cycles_q <= '0;
        end else begin
            if (xoff_now && (pause_frames_q != 16'hFFFF)) begin
                pause_frames_q <= pause_frames_q + 16'd1;
            end
            // Only cycles where a data start was actually held off by pause.
            if ((state == IDLE) && fc.tx_frame_req && !fc.ctrl_frame_req && block) begin
                paused_cycles_q <= paused_cycles_q + 32'd1;
            end
        end
    end

    assign fc.pause_apply      = pause_apply_q;
    assign fc.pause_frames_cnt = pause_frames_q;
    assign fc.paused_cycles    = paused_cycles_q;

endmodule

// File: tb/tb_flow_ctrl_tx_pause.sv
// Purpose: directed self-checking bench for flow_ctrl_tx_pause.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Backpressure: bench plays the TX engine, holding requests until granted.
module tb_flow_ctrl_tx_pause;

    logic tx_clk = 1'b0;
    logic tx_reset;

    flow_ctrl_tx_pause_if fc_if ();

    flow_ctrl_tx_pause #(
        .QUANTA_SHIFT(6),
        .CNT_W       (22)
    ) dut (
        .tx_clk  (tx_clk),
        .tx_reset(tx_reset),
        .fc      (fc_if.slave)
    );

    always #5 tx_clk = ~tx_clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe_pause(input logic [15:0] q);
        fc_if.pause_rcvd        = 1'b1;
        fc_if.pause_quanta_rcvd = q;
        tick();
        fc_if.pause_rcvd        = 1'b0;
        fc_if.pause_quanta_rcvd = 16'd0;
    endtask

    // Called with the FSM in a GO state: engine runs a short frame, FSM ends in IDLE.
    task automatic finish_frame();
        fc_if.tx_frame_busy = 1'b1;
        tick_n(4);
        fc_if.tx_frame_busy = 1'b0;
        tick();
    endtask

    // Bounded wait for a grant; n == limit means it never came.
    task automatic wait_go(input bit ctrl, input int limit, output int n);
        n = 0;
        while (!(ctrl ? fc_if.ctrl_frame_go : fc_if.tx_frame_go) && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int fall_k;
        int go_k;
        int gos;

        tx_reset                 = 1'b1;
        fc_if.pause_respect_en   = 1'b1;
        fc_if.pause_rcvd         = 1'b0;
        fc_if.pause_quanta_rcvd  = 16'd0;
        fc_if.tx_frame_req       = 1'b0;
        fc_if.ctrl_frame_req     = 1'b0;
        fc_if.tx_frame_busy      = 1'b0;
        tick_n(3);

        // ---- reset state ----
        check_val("rst_tx_go",     32'(fc_if.tx_frame_go), 32'd0);
        check_val("rst_ctrl_go",   32'(fc_if.ctrl_frame_go), 32'd0);
        check_val("rst_apply",     32'(fc_if.pause_apply), 32'd0);
        check_val("rst_pfc",       32'(fc_if.pause_frames_cnt), 32'd0);
        check_val("rst_paused",    fc_if.paused_cycles, 32'd0);
        tx_reset = 1'b0;
        tick_n(2);

        // ---- pause timing: quanta 2 -> 128 cycles of pause_apply ----
        strobe_pause(16'd2);
        n = 0;
        while (fc_if.pause_apply && n < 300) begin
            n++;
            tick();
        end
        check_val("apply_len_q2",  n, 32'd128);
        check_val("pfc_after_q2",  32'(fc_if.pause_frames_cnt), 32'd1);
        check_val("paused_idle",   fc_if.paused_cycles, 32'd0);

        // ---- blocked request: request and quanta 1 in the same cycle ----
        // Held off in the strobe cycle (same-cycle term) plus the 64 pause_apply cycles.
        fc_if.tx_frame_req      = 1'b1;
        fc_if.pause_rcvd        = 1'b1;
        fc_if.pause_quanta_rcvd = 16'd1;
        tick();
        fc_if.pause_rcvd        = 1'b0;
        fc_if.pause_quanta_rcvd = 16'd0;
        fall_k = -1;
        go_k   = -1;
        for (int k = 0; k < 200 && go_k < 0; k++) begin
            if (fall_k < 0 && !fc_if.pause_apply) fall_k = k;
            if (fc_if.tx_frame_go) go_k = k;
            if (go_k < 0) tick();
        end
        check_val("blk_apply_fall", fall_k, 32'd64);
        check_val("blk_go_time",    go_k, 32'd65);
        check_val("blk_paused_cyc", fc_if.paused_cycles, 32'd65);
        fc_if.tx_frame_req  = 1'b0;
        fc_if.tx_frame_busy = 1'b1;
        tick();
        check_val("go_one_cycle",   32'(fc_if.tx_frame_go), 32'd0);
        tick_n(3);
        fc_if.tx_frame_busy = 1'b0;
        tick();

        // ---- frame in flight: max PAUSE during WAIT_END ----
        fc_if.tx_frame_req = 1'b1;
        tick();
        check_val("go_unpaused",    32'(fc_if.tx_frame_go), 32'd1);
        fc_if.tx_frame_req  = 1'b0;
        fc_if.tx_frame_busy = 1'b1;
        tick();
        strobe_pause(16'hFFFF);
        check_val("inflight_apply", 32'(fc_if.pause_apply), 32'd1);
        tick_n(3);
        fc_if.tx_frame_req  = 1'b1;
        fc_if.tx_frame_busy = 1'b0;
        tick();
        gos = 0;
        for (int i = 0; i < 20; i++) begin
            if (fc_if.tx_frame_go) gos++;
            tick();
        end
        check_val("data_blocked",   gos, 32'd0);
        fc_if.ctrl_frame_req = 1'b1;
        tick();
        check_val("ctrl_go_paused", 32'(fc_if.ctrl_frame_go), 32'd1);
        check_val("no_data_w_ctrl", 32'(fc_if.tx_frame_go), 32'd0);
        fc_if.ctrl_frame_req = 1'b0;
        finish_frame();
        fc_if.tx_frame_req = 1'b0;
        strobe_pause(16'd0);
        check_val("xon_clear_ffff", 32'(fc_if.pause_apply), 32'd0);
        check_val("pfc_after_ffff", 32'(fc_if.pause_frames_cnt), 32'd3);

        // ---- XON: quanta 10, then quanta 0 100 cycles later ----
        strobe_pause(16'd10);
        tick_n(99);
        check_val("xon_pre_apply",  32'(fc_if.pause_apply), 32'd1);
        strobe_pause(16'd0);
        check_val("xon_drop",       32'(fc_if.pause_apply), 32'd0);
        check_val("pfc_after_xon",  32'(fc_if.pause_frames_cnt), 32'd4);

        // ---- disable mid-pause ----
        strobe_pause(16'd5);
        tick_n(10);
        fc_if.pause_respect_en = 1'b0;
        tick_n(2);
        check_val("dis_apply",      32'(fc_if.pause_apply), 32'd0);
        strobe_pause(16'd7);
        tick();
        check_val("dis_ignore",     32'(fc_if.pause_apply), 32'd0);
        check_val("dis_pfc",        32'(fc_if.pause_frames_cnt), 32'd5);
        fc_if.tx_frame_req = 1'b1;
        tick();
        check_val("dis_go",         32'(fc_if.tx_frame_go), 32'd1);
        fc_if.tx_frame_req = 1'b0;
        finish_frame();
        fc_if.pause_respect_en = 1'b1;

        // ---- async reset mid-pause and mid-WAIT_END ----
        strobe_pause(16'd3);
        fc_if.ctrl_frame_req = 1'b1;
        tick();
        check_val("pre_rst_ctrl",   32'(fc_if.ctrl_frame_go), 32'd1);
        fc_if.ctrl_frame_req = 1'b0;
        fc_if.tx_frame_busy  = 1'b1;
        tick();
        fc_if.tx_frame_req = 1'b1;
        tick_n(2);
        check_val("pre_rst_apply",  32'(fc_if.pause_apply), 32'd1);
        #3;
        tx_reset = 1'b1;
        #1;
        check_val("arst_apply",     32'(fc_if.pause_apply), 32'd0);
        check_val("arst_pfc",       32'(fc_if.pause_frames_cnt), 32'd0);
        check_val("arst_paused",    fc_if.paused_cycles, 32'd0);
        check_val("arst_tx_go",     32'(fc_if.tx_frame_go), 32'd0);
        check_val("arst_ctrl_go",   32'(fc_if.ctrl_frame_go), 32'd0);
        fc_if.tx_frame_busy = 1'b0;
        tick_n(2);
        tx_reset = 1'b0;
        wait_go(1'b0, 5, n);
        check_val("rst_rel_grant",  32'(n >= 1 && n <= 2), 32'd1);
        fc_if.tx_frame_req = 1'b0;
        finish_frame();

        // ---- control priority over a simultaneous data request ----
        fc_if.tx_frame_req   = 1'b1;
        fc_if.ctrl_frame_req = 1'b1;
        tick();
        check_val("prio_ctrl_go",   32'(fc_if.ctrl_frame_go), 32'd1);
        check_val("prio_no_data",   32'(fc_if.tx_frame_go), 32'd0);
        fc_if.ctrl_frame_req = 1'b0;
        finish_frame();
        wait_go(1'b0, 5, n);
        check_val("prio_data_next", 32'(fc_if.tx_frame_go), 32'd1);
        fc_if.tx_frame_req = 1'b0;
        finish_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
